// File: rtl/multicore_run_controller_pkg.sv
// Shared types for the multicore run controller: FSM state encoding, memory-port
// select encoding and small decode helpers used by the top and the bench.
package mp_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_IMEM = 3'd1,
    LOAD_DMEM = 3'd2,
    EXECUTE   = 3'd3,
    UNLOAD    = 3'd4,
    FINISH    = 3'd5,
    ABORT     = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    UART  = 2'd1,
    CORES = 2'd2
  } mem_sel_t;

  // Which agent owns the data-memory port while the controller sits in state s.
  function automatic mem_sel_t mem_sel_for(state_t s);
    case (s)
      LOAD_DMEM, UNLOAD: return UART;
      EXECUTE:           return CORES;
      default:           return NONE;
    endcase
  endfunction

  // States in which a new run request may be accepted.
  function automatic logic accepts_start(state_t s);
    return (s == IDLE) || (s == FINISH) || (s == ABORT);
  endfunction

endpackage

// File: rtl/multicore_run_controller_if.sv
// Snooped UART-side data-memory write bus, observed by the run controller to
// capture run descriptors while the data memory is being loaded.
interface multicore_run_controller_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int REG_WIDTH  = 12
);
  // Valid-only strobe: every cycle with snoop_wr_en high is one write of
  // snoop_data to snoop_addr; there is no ready, the observer never stalls it.
  logic                  snoop_wr_en;
  logic [ADDR_WIDTH-1:0] snoop_addr;
  logic [REG_WIDTH-1:0]  snoop_data;

  modport master (
    output snoop_wr_en,
    output snoop_addr,
    output snoop_data
  );

  modport slave (
    input snoop_wr_en,
    input snoop_addr,
    input snoop_data
  );
endinterface

// File: rtl/multicore_run_controller_run_timer.sv
// Execute-phase cycle counter: synchronous clear, count enable, saturation at
// all-ones, and a timeout flag raised on the cycle the count reaches TIMEOUT_CYC.
module run_timer #(
  parameter int          CNT_WIDTH   = 26,
  parameter int unsigned TIMEOUT_CYC = 2**26 - 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 expired
);

  localparam logic [CNT_WIDTH:0] LIMIT = (CNT_WIDTH + 1)'(TIMEOUT_CYC);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;
  logic [CNT_WIDTH:0]   count_inc;

  always_comb begin
    count_inc = {1'b0, count_q} + (CNT_WIDTH + 1)'(1);
    count_d   = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !(&count_q)) begin
      count_d = count_inc[CNT_WIDTH-1:0];
    end
  end

  // Expires on the enabled cycle whose increment lands on the limit, so the
  // abort edge leaves count == TIMEOUT_CYC.
  assign expired = (TIMEOUT_CYC != 0) && enable && (count_inc >= LIMIT);
  assign count   = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/multicore_run_controller.sv
// Run sequencer for the N-core matrix processor: IMEM load, DMEM load, execute
// with all-core done aggregation and timeout, then result unload.
module multicore_run_controller
  import mp_ctrl_pkg::*;
#(
  parameter int          CORE_COUNT  = 2,
  parameter int          ADDR_WIDTH  = 12,
  parameter int          REG_WIDTH   = 12,
  parameter int          Q_END_LOC   = 7,
  parameter int          R_START_LOC = 5,
  parameter int          R_END_LOC   = 8,
  parameter int unsigned TIMEOUT_CYC = 2**26 - 1,
  parameter int          CNT_WIDTH   = 26
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  reload,
  input  logic                  imem_received,
  input  logic                  dmem_received,
  input  logic                  dmem_transmitted,
  input  logic [CORE_COUNT-1:0] core_done,
  input  logic [CORE_COUNT-1:0] core_ready,
  multicore_run_controller_if.slave snoop,
  output logic [2:0]            state,
  output logic [1:0]            mem_sel,
  output logic                  imem_rx_en,
  output logic                  dmem_rx_en,
  output logic                  process_start,
  output logic                  tx_start,
  output logic [REG_WIDTH-1:0]  rx_end_addr,
  output logic [REG_WIDTH-1:0]  tx_start_addr,
  output logic [REG_WIDTH-1:0]  tx_end_addr,
  output logic [CNT_WIDTH-1:0]  run_cycles,
  output logic                  timeout
);

  if ((Q_END_LOC == R_START_LOC) || (Q_END_LOC == R_END_LOC) || (R_START_LOC == R_END_LOC)) begin : g_loc_check
    $error("multicore_run_controller: descriptor locations must be distinct");
  end

  state_t                state_q, state_d;
  mem_sel_t              mem_sel_q, mem_sel_d;
  logic                  imem_rx_en_q, imem_rx_en_d;
  logic                  dmem_rx_en_q, dmem_rx_en_d;
  logic                  process_start_q, process_start_d;
  logic                  tx_start_q, tx_start_d;
  logic                  timeout_q, timeout_d;
  logic [CORE_COUNT-1:0] done_mask_q, done_mask_d;
  logic [REG_WIDTH-1:0]  rx_end_addr_q, rx_end_addr_d;
  logic [REG_WIDTH-1:0]  tx_start_addr_q, tx_start_addr_d;
  logic [REG_WIDTH-1:0]  tx_end_addr_q, tx_end_addr_d;

  logic                  all_done;
  logic                  timer_clear;
  logic                  timer_enable;
  logic                  timer_expired;
  logic [CNT_WIDTH-1:0]  timer_count;

  // core_ready is status for the host side only; sequencing relies on done levels.
  logic unused_core_ready;
  assign unused_core_ready = ^core_ready;

  assign timer_enable = (state_q == EXECUTE);

  run_timer #(
    .CNT_WIDTH   (CNT_WIDTH),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_run_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .count   (timer_count),
    .expired (timer_expired)
  );

  always_comb begin
    state_d         = state_q;
    process_start_d = 1'b0;
    tx_start_d      = 1'b0;
    timeout_d       = timeout_q;
    done_mask_d     = done_mask_q;
    timer_clear     = 1'b0;
    // Include this cycle's done levels so the last core finishing moves the
    // FSM on the same edge it is first seen.
    all_done        = &(done_mask_q | core_done);

    case (state_q)
      IDLE, FINISH, ABORT: begin
        if (start) begin
          timeout_d = 1'b0;
          if (reload) begin
            state_d = LOAD_IMEM;
          end else begin
            state_d         = EXECUTE;
            process_start_d = 1'b1;
          end
        end
      end
      LOAD_IMEM: begin
        if (imem_received) state_d = LOAD_DMEM;
      end
      LOAD_DMEM: begin
        if (dmem_received) begin
          state_d         = EXECUTE;
          process_start_d = 1'b1;
        end
      end
      EXECUTE: begin
        done_mask_d = done_mask_q | core_done;
        if (all_done) begin
          state_d    = UNLOAD;
          tx_start_d = 1'b1;
        end else if (timer_expired) begin
          state_d   = ABORT;
          timeout_d = 1'b1;
        end
      end
      UNLOAD: begin
        if (dmem_transmitted) state_d = FINISH;
      end
      default: state_d = IDLE;
    endcase

    if ((state_d == EXECUTE) && (state_q != EXECUTE)) begin
      done_mask_d = '0;
      timer_clear = 1'b1;
    end

    // Moore outputs are registered from the next state so they line up with it.
    mem_sel_d    = mem_sel_for(state_d);
    imem_rx_en_d = (state_d == LOAD_IMEM);
    dmem_rx_en_d = (state_d == LOAD_DMEM);
  end

  always_comb begin
    rx_end_addr_d   = rx_end_addr_q;
    tx_start_addr_d = tx_start_addr_q;
    tx_end_addr_d   = tx_end_addr_q;
    if ((state_q == LOAD_DMEM) && snoop.snoop_wr_en) begin
      if (snoop.snoop_addr == ADDR_WIDTH'(Q_END_LOC))   rx_end_addr_d   = snoop.snoop_data;
      if (snoop.snoop_addr == ADDR_WIDTH'(R_START_LOC)) tx_start_addr_d = snoop.snoop_data;
      if (snoop.snoop_addr == ADDR_WIDTH'(R_END_LOC))   tx_end_addr_d   = snoop.snoop_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      mem_sel_q       <= NONE;
      imem_rx_en_q    <= 1'b0;
      dmem_rx_en_q    <= 1'b0;
      process_start_q <= 1'b0;
      tx_start_q      <= 1'b0;
      timeout_q       <= 1'b0;
      done_mask_q     <= '0;
    end else begin
      state_q         <= state_d;
      mem_sel_q       <= mem_sel_d;
      imem_rx_en_q    <= imem_rx_en_d;
      dmem_rx_en_q    <= dmem_rx_en_d;
      process_start_q <= process_start_d;
      tx_start_q      <= tx_start_d;
      timeout_q       <= timeout_d;
      done_mask_q     <= done_mask_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_end_addr_q   <= '0;
      tx_start_addr_q <= '0;
      tx_end_addr_q   <= '0;
    end else begin
      rx_end_addr_q   <= rx_end_addr_d;
      tx_start_addr_q <= tx_start_addr_d;
      tx_end_addr_q   <= tx_end_addr_d;
    end
  end

  assign state         = state_q;
  assign mem_sel       = mem_sel_q;
  assign imem_rx_en    = imem_rx_en_q;
  assign dmem_rx_en    = dmem_rx_en_q;
  assign process_start = process_start_q;
  assign tx_start      = tx_start_q;
  assign rx_end_addr   = rx_end_addr_q;
  assign tx_start_addr = tx_start_addr_q;
  assign tx_end_addr   = tx_end_addr_q;
  assign run_cycles    = timer_count;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_multicore_run_controller.sv
// Directed bench: a 2-core controller for the full run and re-run, a 4-core
// controller with a 100-cycle timeout for abort, done-vs-timeout and async reset.
module tb_multicore_run_controller;

  localparam logic [2:0] S_IDLE = 3'd0, S_LIMEM = 3'd1, S_LDMEM = 3'd2, S_EXEC = 3'd3,
                         S_UNLOAD = 3'd4, S_FINISH = 3'd5, S_ABORT = 3'd6;
  localparam logic [1:0] M_NONE = 2'd0, M_UART = 2'd1, M_CORES = 2'd2;

  logic clk = 1'b0;
  logic a_rst, b_rst;
  logic start, reload, imem_received, dmem_received, dmem_transmitted;
  logic [1:0] a_done, a_ready;
  logic [3:0] b_done, b_ready;

  logic [2:0]  a_state, b_state;
  logic [1:0]  a_mem_sel, b_mem_sel;
  logic        a_imem_rx_en, b_imem_rx_en, a_dmem_rx_en, b_dmem_rx_en;
  logic        a_process_start, b_process_start, a_tx_start, b_tx_start;
  logic [11:0] a_rx_end, b_rx_end, a_tx_saddr, b_tx_saddr, a_tx_eaddr, b_tx_eaddr;
  logic [25:0] a_run_cycles, b_run_cycles;
  logic        a_timeout, b_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  multicore_run_controller_if #(.ADDR_WIDTH(12), .REG_WIDTH(12)) snoop_bus ();

  always #5 clk = ~clk;

  multicore_run_controller #(.CORE_COUNT(2)) dut_a (
    .clk(clk), .rst(a_rst), .start(start), .reload(reload),
    .imem_received(imem_received), .dmem_received(dmem_received),
    .dmem_transmitted(dmem_transmitted), .core_done(a_done), .core_ready(a_ready),
    .snoop(snoop_bus), .state(a_state), .mem_sel(a_mem_sel),
    .imem_rx_en(a_imem_rx_en), .dmem_rx_en(a_dmem_rx_en),
    .process_start(a_process_start), .tx_start(a_tx_start),
    .rx_end_addr(a_rx_end), .tx_start_addr(a_tx_saddr), .tx_end_addr(a_tx_eaddr),
    .run_cycles(a_run_cycles), .timeout(a_timeout)
  );

  multicore_run_controller #(.CORE_COUNT(4), .TIMEOUT_CYC(100)) dut_b (
    .clk(clk), .rst(b_rst), .start(start), .reload(reload),
    .imem_received(imem_received), .dmem_received(dmem_received),
    .dmem_transmitted(dmem_transmitted), .core_done(b_done), .core_ready(b_ready),
    .snoop(snoop_bus), .state(b_state), .mem_sel(b_mem_sel),
    .imem_rx_en(b_imem_rx_en), .dmem_rx_en(b_dmem_rx_en),
    .process_start(b_process_start), .tx_start(b_tx_start),
    .rx_end_addr(b_rx_end), .tx_start_addr(b_tx_saddr), .tx_end_addr(b_tx_eaddr),
    .run_cycles(b_run_cycles), .timeout(b_timeout)
  );

  // ---------------- driver tasks (all stimulus changes happen at negedge) ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_start(input logic rl);
    start = 1'b1; reload = rl;
    tick();
    start = 1'b0; reload = 1'b0;
  endtask

  task automatic pulse_imem();
    imem_received = 1'b1; tick(); imem_received = 1'b0;
  endtask

  task automatic pulse_dmem();
    dmem_received = 1'b1; tick(); dmem_received = 1'b0;
  endtask

  task automatic pulse_tx_done();
    dmem_transmitted = 1'b1; tick(); dmem_transmitted = 1'b0;
  endtask

  task automatic snoop_write(input logic [11:0] addr, input logic [11:0] data);
    snoop_bus.snoop_wr_en = 1'b1; snoop_bus.snoop_addr = addr; snoop_bus.snoop_data = data;
    tick();
    snoop_bus.snoop_wr_en = 1'b0; snoop_bus.snoop_addr = '0; snoop_bus.snoop_data = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1;
    tick();
    n_cmp++; if (a_state !== S_IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", a_state, S_IDLE); end
    n_cmp++; if (a_mem_sel !== M_NONE) begin n_bad++; $display("FAIL reset_mem_sel: got %0d want %0d", a_mem_sel, M_NONE); end
    n_cmp++; if ({a_imem_rx_en, a_dmem_rx_en, a_process_start, a_tx_start, a_timeout} !== 5'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 00000", {a_imem_rx_en, a_dmem_rx_en, a_process_start, a_tx_start, a_timeout}); end
    n_cmp++; if ({a_rx_end, a_tx_saddr, a_tx_eaddr} !== 36'h0) begin
      n_bad++; $display("FAIL reset_desc: got %h want 0", {a_rx_end, a_tx_saddr, a_tx_eaddr}); end
    n_cmp++; if (a_run_cycles !== 26'd0) begin n_bad++; $display("FAIL reset_run_cycles: got %0d want 0", a_run_cycles); end
    a_rst = 1'b0;
    tick();
  endtask

  task automatic test_full_run();
    int tx_seen = 0;
    drive_start(1'b1);
    n_cmp++; if (a_state !== S_LIMEM) begin n_bad++; $display("FAIL full_limem_state: got %0d want %0d", a_state, S_LIMEM); end
    n_cmp++; if (a_imem_rx_en !== 1'b1) begin n_bad++; $display("FAIL full_imem_rx_en: got %b want 1", a_imem_rx_en); end
    n_cmp++; if (a_mem_sel !== M_NONE) begin n_bad++; $display("FAIL full_limem_mem_sel: got %0d want %0d", a_mem_sel, M_NONE); end
    snoop_write(12'd7, 12'h0AB);
    pulse_imem();
    n_cmp++; if (a_state !== S_LDMEM) begin n_bad++; $display("FAIL full_ldmem_state: got %0d want %0d", a_state, S_LDMEM); end
    n_cmp++; if ({a_imem_rx_en, a_dmem_rx_en} !== 2'b01) begin n_bad++; $display("FAIL full_rx_en: got %b want 01", {a_imem_rx_en, a_dmem_rx_en}); end
    n_cmp++; if (a_mem_sel !== M_UART) begin n_bad++; $display("FAIL full_ldmem_mem_sel: got %0d want %0d", a_mem_sel, M_UART); end
    n_cmp++; if (a_rx_end !== 12'h000) begin n_bad++; $display("FAIL snoop_in_limem: got %h want 000", a_rx_end); end
    snoop_write(12'd5, 12'h010);
    n_cmp++; if (a_tx_saddr !== 12'h010) begin n_bad++; $display("FAIL snoop_next_cycle: got %h want 010", a_tx_saddr); end
    snoop_write(12'd7, 12'h00F);
    snoop_write(12'd6, 12'h777);
    snoop_write(12'd8, 12'h018);
    pulse_dmem();
    n_cmp++; if (a_state !== S_EXEC) begin n_bad++; $display("FAIL full_exec_state: got %0d want %0d", a_state, S_EXEC); end
    n_cmp++; if (a_process_start !== 1'b1) begin n_bad++; $display("FAIL full_process_start: got %b want 1", a_process_start); end
    n_cmp++; if (a_mem_sel !== M_CORES) begin n_bad++; $display("FAIL full_exec_mem_sel: got %0d want %0d", a_mem_sel, M_CORES); end
    n_cmp++; if (a_run_cycles !== 26'd0) begin n_bad++; $display("FAIL full_exec_count0: got %0d want 0", a_run_cycles); end
    n_cmp++; if ({a_rx_end, a_tx_saddr, a_tx_eaddr} !== {12'h00F, 12'h010, 12'h018}) begin
      n_bad++; $display("FAIL full_desc: got %h want 00f010018", {a_rx_end, a_tx_saddr, a_tx_eaddr}); end
    // EXECUTE cycle k: core 0 done at 20, core 1 done at 35, stray start/snoop/pulses ignored.
    for (int k = 1; k <= 35; k++) begin
      a_done = (k == 20) ? 2'b01 : (k == 35) ? 2'b10 : 2'b00;
      start = (k == 10); reload = (k == 10);
      dmem_transmitted = (k == 3);
      imem_received = (k == 4);
      if (k == 5) begin
        snoop_bus.snoop_wr_en = 1'b1; snoop_bus.snoop_addr = 12'd7; snoop_bus.snoop_data = 12'h055;
      end
      tick();
      start = 1'b0; reload = 1'b0; dmem_transmitted = 1'b0; imem_received = 1'b0;
      snoop_bus.snoop_wr_en = 1'b0;
      if (a_tx_start === 1'b1) tx_seen++;
      if (k == 1) begin
        n_cmp++; if (a_process_start !== 1'b0) begin n_bad++; $display("FAIL process_start_width: got %b want 0", a_process_start); end
      end
      if (k < 35) begin
        n_cmp++; if (a_state !== S_EXEC) begin n_bad++; $display("FAIL exec_hold_k%0d: got %0d want %0d", k, a_state, S_EXEC); end
      end
    end
    a_done = 2'b00;
    n_cmp++; if (a_state !== S_UNLOAD) begin n_bad++; $display("FAIL full_unload_state: got %0d want %0d", a_state, S_UNLOAD); end
    n_cmp++; if (tx_seen !== 1) begin n_bad++; $display("FAIL full_tx_start_count: got %0d want 1", tx_seen); end
    n_cmp++; if (a_run_cycles !== 26'd35) begin n_bad++; $display("FAIL full_run_cycles: got %0d want 35", a_run_cycles); end
    n_cmp++; if (a_mem_sel !== M_UART) begin n_bad++; $display("FAIL full_unload_mem_sel: got %0d want %0d", a_mem_sel, M_UART); end
    n_cmp++; if (a_rx_end !== 12'h00F) begin n_bad++; $display("FAIL snoop_in_exec: got %h want 00f", a_rx_end); end
    tick();
    n_cmp++; if (a_tx_start !== 1'b0) begin n_bad++; $display("FAIL tx_start_width: got %b want 0", a_tx_start); end
    n_cmp++; if (a_run_cycles !== 26'd35) begin n_bad++; $display("FAIL run_cycles_hold: got %0d want 35", a_run_cycles); end
    pulse_tx_done();
    n_cmp++; if (a_state !== S_FINISH) begin n_bad++; $display("FAIL full_finish_state: got %0d want %0d", a_state, S_FINISH); end
    n_cmp++; if (a_mem_sel !== M_NONE) begin n_bad++; $display("FAIL full_finish_mem_sel: got %0d want %0d", a_mem_sel, M_NONE); end
  endtask

  task automatic test_rerun();
    drive_start(1'b0);
    n_cmp++; if (a_state !== S_EXEC) begin n_bad++; $display("FAIL rerun_state: got %0d want %0d", a_state, S_EXEC); end
    n_cmp++; if (a_process_start !== 1'b1) begin n_bad++; $display("FAIL rerun_process_start: got %b want 1", a_process_start); end
    n_cmp++; if (a_run_cycles !== 26'd0) begin n_bad++; $display("FAIL rerun_count0: got %0d want 0", a_run_cycles); end
    n_cmp++; if ({a_rx_end, a_tx_saddr, a_tx_eaddr} !== {12'h00F, 12'h010, 12'h018}) begin
      n_bad++; $display("FAIL rerun_desc: got %h want 00f010018", {a_rx_end, a_tx_saddr, a_tx_eaddr}); end
    a_done = 2'b01; tick();
    n_cmp++; if (a_state !== S_EXEC) begin n_bad++; $display("FAIL rerun_mask_cleared: got %0d want %0d", a_state, S_EXEC); end
    a_done = 2'b00; tick();
    a_done = 2'b10; tick();
    a_done = 2'b00;
    n_cmp++; if (a_state !== S_UNLOAD) begin n_bad++; $display("FAIL rerun_unload: got %0d want %0d", a_state, S_UNLOAD); end
    n_cmp++; if (a_run_cycles !== 26'd3) begin n_bad++; $display("FAIL rerun_run_cycles: got %0d want 3", a_run_cycles); end
    pulse_tx_done();
    a_rst = 1'b1;
  endtask

  task automatic test_timeout();
    b_rst = 1'b0;
    tick();
    pulse_imem();
    n_cmp++; if (b_state !== S_IDLE) begin n_bad++; $display("FAIL idle_ignores_pulse: got %0d want %0d", b_state, S_IDLE); end
    drive_start(1'b1);
    pulse_imem();
    pulse_dmem();
    b_done = 4'b0001;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (k < 100) begin
        n_cmp++; if (b_state !== S_EXEC) begin n_bad++; $display("FAIL to_hold_k%0d: got %0d want %0d", k, b_state, S_EXEC); end
        n_cmp++; if (b_tx_start !== 1'b0) begin n_bad++; $display("FAIL to_no_tx_k%0d: got %b want 0", k, b_tx_start); end
      end
    end
    b_done = 4'b0000;
    n_cmp++; if (b_state !== S_ABORT) begin n_bad++; $display("FAIL to_abort_state: got %0d want %0d", b_state, S_ABORT); end
    n_cmp++; if (b_timeout !== 1'b1) begin n_bad++; $display("FAIL to_timeout_flag: got %b want 1", b_timeout); end
    n_cmp++; if (b_run_cycles !== 26'd100) begin n_bad++; $display("FAIL to_run_cycles: got %0d want 100", b_run_cycles); end
    n_cmp++; if ({b_mem_sel, b_tx_start} !== 3'b000) begin n_bad++; $display("FAIL to_abort_outputs: got %b want 000", {b_mem_sel, b_tx_start}); end
    tick();
    n_cmp++; if (b_timeout !== 1'b1) begin n_bad++; $display("FAIL to_sticky: got %b want 1", b_timeout); end
  endtask

  task automatic test_done_on_timeout_cycle();
    drive_start(1'b0);
    n_cmp++; if (b_state !== S_EXEC) begin n_bad++; $display("FAIL dt_exec_state: got %0d want %0d", b_state, S_EXEC); end
    n_cmp++; if (b_timeout !== 1'b0) begin n_bad++; $display("FAIL dt_timeout_cleared: got %b want 0", b_timeout); end
    n_cmp++; if (b_run_cycles !== 26'd0) begin n_bad++; $display("FAIL dt_count0: got %0d want 0", b_run_cycles); end
    for (int k = 1; k <= 100; k++) begin
      b_done = (k == 30) ? 4'b0010 : (k == 50) ? 4'b0100 : (k == 100) ? 4'b1001 : 4'b0000;
      tick();
      if (k < 100) begin
        n_cmp++; if (b_state !== S_EXEC) begin n_bad++; $display("FAIL dt_hold_k%0d: got %0d want %0d", k, b_state, S_EXEC); end
      end
    end
    b_done = 4'b0000;
    n_cmp++; if (b_state !== S_UNLOAD) begin n_bad++; $display("FAIL dt_done_wins: got %0d want %0d", b_state, S_UNLOAD); end
    n_cmp++; if (b_tx_start !== 1'b1) begin n_bad++; $display("FAIL dt_tx_start: got %b want 1", b_tx_start); end
    n_cmp++; if (b_timeout !== 1'b0) begin n_bad++; $display("FAIL dt_no_timeout: got %b want 0", b_timeout); end
    n_cmp++; if (b_run_cycles !== 26'd100) begin n_bad++; $display("FAIL dt_run_cycles: got %0d want 100", b_run_cycles); end
    pulse_tx_done();
  endtask

  task automatic test_async_reset();
    drive_start(1'b0);
    repeat (10) tick();
    n_cmp++; if (b_run_cycles !== 26'd10) begin n_bad++; $display("FAIL ar_pre_count: got %0d want 10", b_run_cycles); end
    #2 b_rst = 1'b1;
    #1;
    n_cmp++; if (b_state !== S_IDLE) begin n_bad++; $display("FAIL ar_state: got %0d want %0d", b_state, S_IDLE); end
    n_cmp++; if (b_mem_sel !== M_NONE) begin n_bad++; $display("FAIL ar_mem_sel: got %0d want %0d", b_mem_sel, M_NONE); end
    n_cmp++; if (b_run_cycles !== 26'd0) begin n_bad++; $display("FAIL ar_run_cycles: got %0d want 0", b_run_cycles); end
    tick();
    n_cmp++; if ({b_process_start, b_tx_start, b_timeout} !== 3'b000) begin
      n_bad++; $display("FAIL ar_no_pulses: got %b want 000", {b_process_start, b_tx_start, b_timeout}); end
    b_rst = 1'b0;
    tick();
    n_cmp++; if (b_state !== S_IDLE) begin n_bad++; $display("FAIL ar_stays_idle: got %0d want %0d", b_state, S_IDLE); end
  endtask

  initial begin
    start = 1'b0; reload = 1'b0;
    imem_received = 1'b0; dmem_received = 1'b0; dmem_transmitted = 1'b0;
    a_done = '0; b_done = '0; a_ready = '1; b_ready = '1;
    snoop_bus.snoop_wr_en = 1'b0; snoop_bus.snoop_addr = '0; snoop_bus.snoop_data = '0;
    test_reset();
    test_full_run();
    test_rerun();
    test_timeout();
    test_done_on_timeout_cycle();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
